// File: rtl/flight_stage_sequencer_pkg.sv
// Shared constants for the flight-stage sequencer.
// Holds state encodings, default timing values and a small saturating helper.
package flight_stage_sequencer_pkg;

   localparam int SEQ_NUM_STAGES       = 4;
   localparam int SEQ_STAGE_TIMEOUT_US = 500;
   localparam int SEQ_IMU_TIMEOUT_US   = 20000;
   localparam int SEQ_MAX_FAULTS       = 3;

   typedef logic [1:0] seq_state_t;

   localparam logic [1:0] SEQ_STATE_IDLE   = 2'd0;
   localparam logic [1:0] SEQ_STATE_LAUNCH = 2'd1;
   localparam logic [1:0] SEQ_STATE_WAIT   = 2'd2;
   localparam logic [1:0] SEQ_STATE_FAULT  = 2'd3;

   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      logic [7:0] result;
      if (value == 8'hFF) begin
         result = value;
      end else begin
         result = value + 8'd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/flight_stage_sequencer_timer.sv
// Saturating timeout counter with synchronous clear; expired is high while the
// count sits at LIMIT.
module seq_timeout_timer #(
   parameter int LIMIT = 1,
   parameter int WIDTH = $clog2(LIMIT + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

   logic [WIDTH-1:0] count;

   // Up-counter; clear wins over enable and the count holds once it reaches LIMIT.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != LIMIT_V)) begin
         count <= count + WIDTH'(1);
      end else begin
         count <= count;
      end
   end

   assign expired = (count == LIMIT_V);

endmodule

// File: rtl/flight_stage_sequencer.sv
// Per-frame scheduler for the flight-control stage chain: one start strobe per stage,
// stage timeout, overrun accounting, fault latch and the motor-enable gate.
module flight_stage_sequencer
   import flight_stage_sequencer_pkg::*;
#(
   parameter int NUM_STAGES       = SEQ_NUM_STAGES,
   parameter int STAGE_TIMEOUT_US = SEQ_STAGE_TIMEOUT_US,
   parameter int IMU_TIMEOUT_US   = SEQ_IMU_TIMEOUT_US,
   parameter int MAX_FAULTS       = SEQ_MAX_FAULTS
) (
   input  logic                  us_clk,
   input  logic                  reset,
   input  logic                  imu_valid_i,
   input  logic [NUM_STAGES-1:0] complete_i,
   input  logic [NUM_STAGES-1:0] active_i,
   input  logic                  arm_i,
   output logic [NUM_STAGES-1:0] start_o,
   output logic                  frame_done_o,
   output logic                  motor_enable_o,
   output logic                  fault_o,
   output logic                  busy_o,
   output logic [7:0]            overrun_cnt_o,
   output logic [2:0]            last_stage_o
);

   localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
   localparam int FW = $clog2(MAX_FAULTS + 1);
   localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);
   localparam logic [FW-1:0] FAULT_LAST = FW'(MAX_FAULTS - 1);

   seq_state_t            state;
   seq_state_t            next_state;
   logic [SW-1:0]         stage;
   logic [SW-1:0]         next_stage;
   logic [FW-1:0]         fault_cnt;
   logic                  pending;
   logic                  arm_q;
   logic                  seen_frame;
   logic                  stage_expired;
   logic                  imu_timeout;
   logic                  in_frame;
   logic                  arm_rise;
   logic                  frame_end;
   logic                  abort;
   logic                  fault_clear;
   logic [NUM_STAGES-1:0] start_next;
   logic                  unused_status;

   // active_i is reported by the stages for status only.
   assign unused_status = ^active_i;

   assign in_frame    = (state == SEQ_STATE_LAUNCH) || (state == SEQ_STATE_WAIT);
   assign arm_rise    = arm_i & ~arm_q;
   assign fault_clear = (state == SEQ_STATE_FAULT) && arm_rise;

   seq_timeout_timer #(
      .LIMIT (STAGE_TIMEOUT_US - 1),
      .WIDTH ($clog2(STAGE_TIMEOUT_US + 1))
   ) u_stage_timer (
      .clk     (us_clk),
      .reset   (reset),
      .clear   (state != SEQ_STATE_WAIT),
      .enable  (state == SEQ_STATE_WAIT),
      .expired (stage_expired)
   );

   seq_timeout_timer #(
      .LIMIT (IMU_TIMEOUT_US),
      .WIDTH ($clog2(IMU_TIMEOUT_US + 1))
   ) u_imu_wdog (
      .clk     (us_clk),
      .reset   (reset),
      .clear   (imu_valid_i),
      .enable  (1'b1),
      .expired (imu_timeout)
   );

   // Next-state logic; a completion only counts for the stage currently being waited on.
   always_comb begin
      next_state = state;
      next_stage = stage;
      frame_end  = 1'b0;
      abort      = 1'b0;
      start_next = '0;
      case (state)
         SEQ_STATE_IDLE: begin
            if (imu_valid_i || pending) begin
               next_state = SEQ_STATE_LAUNCH;
               next_stage = '0;
            end else begin
               next_state = SEQ_STATE_IDLE;
            end
         end
         SEQ_STATE_LAUNCH: begin
            next_state = SEQ_STATE_WAIT;
         end
         SEQ_STATE_WAIT: begin
            if (complete_i[stage]) begin
               if (stage == LAST_STAGE) begin
                  frame_end  = 1'b1;
                  next_state = SEQ_STATE_IDLE;
               end else begin
                  next_stage = stage + SW'(1);
                  next_state = SEQ_STATE_LAUNCH;
               end
            end else if (stage_expired) begin
               abort      = 1'b1;
               next_state = (fault_cnt >= FAULT_LAST) ? SEQ_STATE_FAULT : SEQ_STATE_IDLE;
            end else begin
               next_state = SEQ_STATE_WAIT;
            end
         end
         SEQ_STATE_FAULT: begin
            if (arm_rise) begin
               next_state = SEQ_STATE_IDLE;
            end else begin
               next_state = SEQ_STATE_FAULT;
            end
         end
         default: begin
            next_state = SEQ_STATE_IDLE;
         end
      endcase
      if (next_state == SEQ_STATE_LAUNCH) begin
         start_next[next_stage] = 1'b1;
      end else begin
         start_next = '0;
      end
   end

   // State, bookkeeping and registered outputs.
   always_ff @(posedge us_clk) begin
      if (reset) begin
         state          <= SEQ_STATE_IDLE;
         stage          <= '0;
         fault_cnt      <= '0;
         pending        <= 1'b0;
         arm_q          <= 1'b0;
         seen_frame     <= 1'b0;
         start_o        <= '0;
         frame_done_o   <= 1'b0;
         motor_enable_o <= 1'b0;
         fault_o        <= 1'b0;
         busy_o         <= 1'b0;
         overrun_cnt_o  <= 8'd0;
         last_stage_o   <= 3'd0;
      end else begin
         state          <= next_state;
         stage          <= next_stage;
         arm_q          <= arm_i;
         start_o        <= start_next;
         frame_done_o   <= frame_end;
         busy_o         <= (next_state == SEQ_STATE_LAUNCH) || (next_state == SEQ_STATE_WAIT);
         fault_o        <= (next_state == SEQ_STATE_FAULT);
         motor_enable_o <= arm_i & ~fault_o & ~imu_timeout & seen_frame;

         // A fault discards any queued frame so re-arming starts from a fresh IMU sample.
         if ((next_state == SEQ_STATE_FAULT) || (state == SEQ_STATE_IDLE)) begin
            pending <= 1'b0;
         end else if (in_frame && imu_valid_i) begin
            pending <= 1'b1;
         end else begin
            pending <= pending;
         end

         if (in_frame && imu_valid_i && pending) begin
            overrun_cnt_o <= sat_inc8(overrun_cnt_o);
         end else begin
            overrun_cnt_o <= overrun_cnt_o;
         end

         if (frame_end || fault_clear) begin
            fault_cnt <= '0;
         end else if (abort) begin
            fault_cnt <= fault_cnt + FW'(1);
         end else begin
            fault_cnt <= fault_cnt;
         end

         if (abort) begin
            last_stage_o <= 3'(stage);
         end else begin
            last_stage_o <= last_stage_o;
         end

         if (frame_end) begin
            seen_frame <= 1'b1;
         end else if (fault_clear) begin
            seen_frame <= 1'b0;
         end else begin
            seen_frame <= seen_frame;
         end
      end
   end

endmodule

// File: tb/tb_flight_stage_sequencer.sv
// Randomized self-checking bench for flight_stage_sequencer with a frame-level
// reference model; every cycle's outputs are compared against the model.
module tb_flight_stage_sequencer;

   localparam int NS     = 4;
   localparam int STO    = 500;
   localparam int IMU_TO = 20000;
   localparam int MAXF   = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          imu_valid = 1'b0;
   logic [NS-1:0] complete = '0;
   logic [NS-1:0] active = '0;
   logic          arm = 1'b1;
   logic [NS-1:0] start_o;
   logic          frame_done_o;
   logic          motor_enable_o;
   logic          fault_o;
   logic          busy_o;
   logic [7:0]    overrun_cnt_o;
   logic [2:0]    last_stage_o;

   flight_stage_sequencer dut (
      .us_clk         (clk),
      .reset          (rst),
      .imu_valid_i    (imu_valid),
      .complete_i     (complete),
      .active_i       (active),
      .arm_i          (arm),
      .start_o        (start_o),
      .frame_done_o   (frame_done_o),
      .motor_enable_o (motor_enable_o),
      .fault_o        (fault_o),
      .busy_o         (busy_o),
      .overrun_cnt_o  (overrun_cnt_o),
      .last_stage_o   (last_stage_o)
   );

   always #5 clk = ~clk;

   int    n_vec = 0;
   int    n_err = 0;
   int    n_done = 0;
   string phase = "reset";

   // stimulus: per-stage completion countdown (-1 = none scheduled)
   int cd [NS];
   int dmin = 3;
   int dmax = 3;
   int hang_stage = -1;
   int hang_permil = 0;

   // reference model, expressed as frame / stage / elapsed-cycle bookkeeping
   bit            m_frame, m_faulted, m_pend, m_seen, m_arm_prev;
   int            m_cur, m_elapsed, m_fails, m_since, m_ovr, m_last;
   logic [NS-1:0] m_start;
   logic          m_done, m_motor;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step();
      if (rst) begin
         m_frame = 0; m_faulted = 0; m_pend = 0; m_seen = 0;
         m_cur = 0; m_elapsed = 0; m_fails = 0; m_since = 0; m_ovr = 0; m_last = 0;
         m_start = '0; m_done = 1'b0; m_motor = 1'b0;
      end else begin
         m_motor = arm && !m_faulted && (m_since < IMU_TO) && m_seen;
         m_start = '0;
         m_done  = 1'b0;
         if (m_frame && imu_valid) begin
            if (m_pend) m_ovr = (m_ovr < 255) ? m_ovr + 1 : 255;
            m_pend = 1;
         end
         if (m_faulted) begin
            if (arm && !m_arm_prev) begin
               m_faulted = 0; m_fails = 0; m_seen = 0;
            end
         end else if (!m_frame) begin
            if (imu_valid || m_pend) begin
               m_frame = 1; m_cur = 0; m_pend = 0; m_elapsed = 0; m_start[0] = 1'b1;
            end
         end else if (m_elapsed > 0 && complete[m_cur]) begin
            if (m_cur == NS - 1) begin
               m_frame = 0; m_done = 1'b1; m_fails = 0; m_seen = 1;
            end else begin
               m_cur++; m_elapsed = 0; m_start[m_cur] = 1'b1;
            end
         end else if (m_elapsed == STO) begin
            m_frame = 0; m_fails++; m_last = m_cur;
            if (m_fails >= MAXF) begin
               m_faulted = 1; m_pend = 0;
            end
         end else begin
            m_elapsed++;
         end
         m_since = imu_valid ? 0 : ((m_since < IMU_TO) ? m_since + 1 : IMU_TO);
      end
      m_arm_prev = rst ? 1'b0 : arm;
   endtask

   function automatic logic [31:0] expected_vec();
      return {13'd0, m_start, m_done, m_motor, m_faulted, m_frame, 8'(m_ovr), 3'(m_last)};
   endfunction

   task automatic step(input logic imu, input logic [NS-1:0] extra);
      logic [NS-1:0] c;
      c = extra;
      for (int i = 0; i < NS; i++) begin
         if (cd[i] == 0) begin
            c[i] = 1'b1;
            cd[i] = -1;
         end else if (cd[i] > 0) begin
            cd[i] = cd[i] - 1;
         end
      end
      imu_valid = imu;
      complete  = c;
      active    = 4'($urandom);
      @(posedge clk);
      model_step();
      #1;
      check_value(phase, {13'd0, start_o, frame_done_o, motor_enable_o, fault_o, busy_o,
                          overrun_cnt_o, last_stage_o}, expected_vec());
      if (frame_done_o) n_done++;
      for (int i = 0; i < NS; i++) begin
         if (m_start[i] && (i != hang_stage) && ($urandom_range(999, 0) >= hang_permil))
            cd[i] = $urandom_range(dmax, dmin) - 1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1'b0, '0);
      step(1'b0, '0);
      rst = 1'b0;
      for (int i = 0; i < NS; i++) cd[i] = -1;
   endtask

   initial begin
      for (int i = 0; i < NS; i++) cd[i] = -1;
      do_reset();
      check_value("reset_outputs", {13'd0, start_o, frame_done_o, motor_enable_o, fault_o, busy_o,
                                    overrun_cnt_o, last_stage_o}, 32'd0);

      // basic frame, each stage completes 3 cycles after its start
      phase = "basic"; n_done = 0;
      step(1'b1, '0);
      repeat (29) step(1'b0, '0);
      check_value("basic_done_cnt", n_done, 32'd1);
      check_value("basic_motor", motor_enable_o, 32'd1);

      // stage 2 hangs for three frames, then re-arm
      phase = "timeout"; do_reset(); hang_stage = 2;
      for (int f = 0; f < 3; f++) begin
         step(1'b1, '0);
         repeat (599) step(1'b0, '0);
         check_value("timeout_fault", fault_o, (f == 2) ? 32'd1 : 32'd0);
      end
      check_value("timeout_last_stage", last_stage_o, 32'd2);
      check_value("timeout_motor", motor_enable_o, 32'd0);
      arm = 1'b0; repeat (3) step(1'b0, '0);
      arm = 1'b1; repeat (2) step(1'b0, '0);
      check_value("rearm_fault", fault_o, 32'd0);
      hang_stage = -1; n_done = 0;
      step(1'b1, '0);
      repeat (40) step(1'b0, '0);
      check_value("rearm_done_cnt", n_done, 32'd1);
      check_value("rearm_motor", motor_enable_o, 32'd1);

      // three strobes during one busy frame
      phase = "overrun"; do_reset(); dmin = 5; dmax = 5; n_done = 0;
      for (int i = 0; i < 80; i++) step((i == 0) || (i == 3) || (i == 6) || (i == 9), '0);
      check_value("overrun_cnt", overrun_cnt_o, 32'd2);
      check_value("overrun_done_cnt", n_done, 32'd2);

      // IMU silence
      phase = "imu_wdog";
      repeat (20010) step(1'b0, '0);
      check_value("wdog_motor", motor_enable_o, 32'd0);
      check_value("wdog_fault", fault_o, 32'd0);
      step(1'b1, '0);
      repeat (40) step(1'b0, '0);
      check_value("wdog_recover", motor_enable_o, 32'd1);

      // reset while waiting on stage 1
      phase = "mid_reset"; do_reset(); dmin = 4; dmax = 4;
      step(1'b1, '0);
      for (int k = 0; k < 50 && !(m_frame && m_cur == 1 && m_elapsed >= 2); k++) step(1'b0, '0);
      check_value("mid_reset_busy", busy_o, 32'd1);
      rst = 1'b1; step(1'b0, '0); rst = 1'b0;
      check_value("mid_reset_outputs", {start_o, busy_o}, 32'd0);
      n_done = 0;
      step(1'b0, 4'b0010);
      repeat (10) step(1'b0, '0);
      check_value("mid_reset_no_done", n_done, 32'd0);
      check_value("mid_reset_idle", busy_o, 32'd0);

      // stray completion for stage 3 while waiting on stage 0
      phase = "stray"; dmin = 6; dmax = 6; n_done = 0;
      step(1'b1, '0); step(1'b0, '0); step(1'b0, '0);
      step(1'b0, 4'b1000);
      repeat (40) step(1'b0, '0);
      check_value("stray_done_cnt", n_done, 32'd1);

      // overrun counter saturation
      phase = "saturate"; do_reset(); hang_stage = 0;
      repeat (400) step(1'b1, '0);
      check_value("overrun_sat", overrun_cnt_o, 32'd255);
      hang_stage = -1;

      // randomized traffic
      phase = "random"; do_reset(); dmin = 1; dmax = 12; hang_permil = 40;
      for (int n = 0; n < 5000; n++) begin
         if ($urandom_range(499, 0) == 0) arm = ~arm;
         rst = ($urandom_range(1999, 0) == 0);
         step($urandom_range(39, 0) == 0, ($urandom_range(49, 0) == 0) ? 4'($urandom) : 4'b0000);
      end
      rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
